stereo_i2s_tx: RTL and testbench

STEREO_I2S_TX -- requirements
Module: stereo_i2s_tx

---
 rtl/stereo_i2s_tx.sv | 87 ++++++++
 tb/tb_stereo_i2s_tx.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_i2s_tx.sv
// Stereo I2S transmitter: divides clk_in into BCLK, frames 32 BCLKs per stereo
// sample (16 bits per channel, MSB first, one-bit I2S delay) and requests samples.
module stereo_i2s_tx #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        bclk_out,
  output logic        lrclk_out,
  output logic        sdata_out,
  output logic        sample_req,
  output logic [7:0]  underrun_cnt
);

  localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [4:0]       bit_cnt_nxt;
  logic [31:0]      shift_reg;
  logic [31:0]      hold_reg;
  logic             pending;
  logic             div_wrap;
  logic             fall_evt;
  logic             load_evt;

  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    fall_evt    = div_wrap && bclk_out;
    load_evt    = fall_evt && (bit_cnt == 5'd0);
    bit_cnt_nxt = bit_cnt + 5'd1;
  end

  // sdata is the shift register MSB directly, so it only moves on fall events
  assign sdata_out = shift_reg[31];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      bclk_out     <= 1'b0;
      lrclk_out    <= 1'b0;
      shift_reg    <= '0;
      hold_reg     <= '0;
      pending      <= 1'b0;
      sample_req   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      sample_req <= load_evt;

      if (div_wrap) begin
        div_cnt  <= '0;
        bclk_out <= ~bclk_out;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (fall_evt) begin
        bit_cnt   <= bit_cnt_nxt;
        lrclk_out <= bit_cnt_nxt[4];
        if (load_evt) begin
          shift_reg <= hold_reg;
        end else begin
          shift_reg <= {shift_reg[30:0], 1'b0};
        end
      end

      // A strobe coinciding with a load lands in holding after the shift
      // register has taken the old value, and keeps pending set.
      if (sample_valid) begin
        hold_reg <= {sample_l, sample_r};
        pending  <= 1'b1;
      end else if (load_evt) begin
        pending <= 1'b0;
      end

      if (load_evt && !pending && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_stereo_i2s_tx.sv
// Directed bench for stereo_i2s_tx: three instances at BCLK_DIV = 2, 4 and 7
// sharing clock, reset and sample inputs.
module tb_stereo_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic [2:0]  bclk;
  logic [2:0]  lrclk;
  logic [2:0]  sdata;
  logic [2:0]  sreq;
  logic [7:0]  urc [3];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stereo_i2s_tx #(.BCLK_DIV(2)) dut2 (
    .clk_in(clk), .rst_in(rst_in), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .bclk_out(bclk[0]), .lrclk_out(lrclk[0]),
    .sdata_out(sdata[0]), .sample_req(sreq[0]), .underrun_cnt(urc[0])
  );
  stereo_i2s_tx #(.BCLK_DIV(4)) dut4 (
    .clk_in(clk), .rst_in(rst_in), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .bclk_out(bclk[1]), .lrclk_out(lrclk[1]),
    .sdata_out(sdata[1]), .sample_req(sreq[1]), .underrun_cnt(urc[1])
  );
  stereo_i2s_tx #(.BCLK_DIV(7)) dut7 (
    .clk_in(clk), .rst_in(rst_in), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .bclk_out(bclk[2]), .lrclk_out(lrclk[2]),
    .sdata_out(sdata[2]), .sample_req(sreq[2]), .underrun_cnt(urc[2])
  );

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 7;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after the first post-reset posedge.
  task automatic apply_reset(input logic [15:0] l, input logic [15:0] r, input logic with_sample);
    rst_in = 1'b1;
    sample_valid = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    sample_valid = with_sample;
    sample_l = l;
    sample_r = r;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_req(input int k, output int unsigned stamp, output bit ok);
    ok = 1'b0;
    stamp = 0;
    for (int i = 0; i < 64 * div_of(k) + 16; i++) begin
      if (sreq[k]) begin
        ok = 1'b1;
        stamp = cyc;
        break;
      end
      tick();
    end
  endtask

  // Collects the 32 bits seen at BCLK rises following a sample_req pulse.
  task automatic capture_frame(input int k, output logic [31:0] bits,
                               output int unsigned stamp, output int lr_bad, output bit ok);
    logic prev;
    int   n;
    bits = '0;
    lr_bad = 0;
    n = 0;
    wait_req(k, stamp, ok);
    if (ok) begin
      prev = bclk[k];
      for (int i = 0; i < 2 * div_of(k) * 34 && n < 32; i++) begin
        tick();
        if (bclk[k] && !prev) begin
          bits = {bits[30:0], sdata[k]};
          if (lrclk[k] !== ((n >= 15) && (n <= 30))) lr_bad++;
          n++;
        end
        prev = bclk[k];
      end
      if (n != 32) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    sample_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({bclk[1], lrclk[1], sdata[1], sreq[1], urc[1]} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got bclk/lr/sd/req=%b urc=%0d, expected 0000 urc=0",
               {bclk[1], lrclk[1], sdata[1], sreq[1]}, urc[1]);
    end
    rst_in = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 3) begin
        checks++;
        if (bclk[1] !== 1'b0) begin
          errors++; $display("FAIL bclk_pre_rise: got %b at clk 3, expected 0", bclk[1]);
        end
      end
      if (t == 4) begin
        checks++;
        if (bclk[1] !== 1'b1) begin
          errors++; $display("FAIL bclk_first_rise: got %b at clk 4, expected 1", bclk[1]);
        end
      end
      if (t == 7) begin
        checks++;
        if (sreq[1] !== 1'b0) begin
          errors++; $display("FAIL req_early: got %b at clk 7, expected 0", sreq[1]);
        end
      end
      if (t == 8) begin
        checks++;
        if (sreq[1] !== 1'b1 || urc[1] !== 8'd1) begin
          errors++;
          $display("FAIL first_load: got req=%b urc=%0d at clk 8, expected req=1 urc=1", sreq[1], urc[1]);
        end
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] bits;
    int unsigned st, f0, f1;
    int          lr_bad, nf;
    bit          ok;
    logic        prev;
    apply_reset(16'hA5C3, 16'h0F0F, 1'b1);
    capture_frame(1, bits, st, lr_bad, ok);
    checks++;
    if (!ok || bits !== 32'hA5C3_0F0F) begin
      errors++; $display("FAIL basic_bits: got %h ok=%0d, expected a5c30f0f", bits, ok);
    end
    checks++;
    if (lr_bad != 0) begin
      errors++; $display("FAIL basic_lrclk: got %0d misplaced lrclk samples, expected 0", lr_bad);
    end
    checks++;
    if (urc[1] !== 8'd0) begin
      errors++; $display("FAIL basic_underrun: got %0d, expected 0", urc[1]);
    end
    f0 = 0;
    f1 = 0;
    nf = 0;
    prev = lrclk[1];
    for (int i = 0; i < 700 && nf < 2; i++) begin
      tick();
      if (!lrclk[1] && prev) begin
        if (nf == 0) f0 = cyc; else f1 = cyc;
        nf++;
      end
      prev = lrclk[1];
    end
    checks++;
    if (nf != 2 || (f1 - f0) != 256) begin
      errors++; $display("FAIL lrclk_period: got %0d (falls seen %0d), expected 256", f1 - f0, nf);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] bits;
    int unsigned st, last_st;
    int          lr_bad;
    bit          ok;
    apply_reset(16'h9ABC, 16'h1357, 1'b1);
    last_st = 0;
    for (int f = 0; f < 4; f++) begin
      capture_frame(1, bits, st, lr_bad, ok);
      checks++;
      if (!ok || bits !== 32'h9ABC_1357) begin
        errors++; $display("FAIL underrun_frame%0d: got %h ok=%0d, expected 9abc1357", f, bits, ok);
      end
      if (f > 0) begin
        checks++;
        if ((st - last_st) != 256) begin
          errors++; $display("FAIL req_spacing%0d: got %0d, expected 256", f, st - last_st);
        end
      end
      last_st = st;
    end
    checks++;
    if (urc[1] !== 8'd3) begin
      errors++; $display("FAIL underrun_count: got %0d, expected 3", urc[1]);
    end
  endtask

  task automatic test_collision();
    logic [31:0] bits;
    int unsigned st;
    int          lr_bad;
    bit          ok;
    apply_reset(16'h1234, 16'h5678, 1'b1);
    for (int i = 2; i <= 7; i++) tick();
    sample_valid = 1'b1;
    sample_l = 16'h8000;
    sample_r = 16'h7FFF;
    tick();
    sample_valid = 1'b0;
    checks++;
    if (sreq[1] !== 1'b1) begin
      errors++; $display("FAIL collision_align: got req=%b, expected 1", sreq[1]);
    end
    capture_frame(1, bits, st, lr_bad, ok);
    checks++;
    if (!ok || bits !== 32'h1234_5678) begin
      errors++; $display("FAIL collision_cur: got %h ok=%0d, expected 12345678", bits, ok);
    end
    capture_frame(1, bits, st, lr_bad, ok);
    checks++;
    if (!ok || bits !== 32'h8000_7FFF) begin
      errors++; $display("FAIL collision_next: got %h ok=%0d, expected 80007fff", bits, ok);
    end
    checks++;
    if (urc[1] !== 8'd0) begin
      errors++; $display("FAIL collision_underrun: got %0d, expected 0", urc[1]);
    end
  endtask

  task automatic test_saturation();
    rst_in = 1'b1;
    sample_valid = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 38408; i++) tick();
    checks++;
    if (urc[0] !== 8'd255) begin
      errors++; $display("FAIL sat_div2: got %0d, expected 255", urc[0]);
    end
    checks++;
    if (urc[1] !== 8'd151) begin
      errors++; $display("FAIL count_div4: got %0d, expected 151", urc[1]);
    end
    checks++;
    if (urc[2] !== 8'd86) begin
      errors++; $display("FAIL count_div7: got %0d, expected 86", urc[2]);
    end
    for (int i = 0; i < 600; i++) tick();
    checks++;
    if (urc[0] !== 8'd255) begin
      errors++; $display("FAIL sat_hold: got %0d, expected 255", urc[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] bits;
    int unsigned st;
    int          lr_bad;
    bit          ok;
    apply_reset(16'hFFFF, 16'hFFFF, 1'b1);
    wait_req(1, st, ok);
    for (int i = 0; i < 156; i++) tick();
    checks++;
    if (!ok || lrclk[1] !== 1'b1 || sdata[1] !== 1'b1 || bclk[1] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre: got lr=%b sd=%b bclk=%b ok=%0d, expected 1 1 1 1",
               lrclk[1], sdata[1], bclk[1], ok);
    end
    rst_in = 1'b1;
    tick();
    checks++;
    if ({bclk[1], lrclk[1], sdata[1], sreq[1], urc[1]} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset: got bclk/lr/sd/req=%b urc=%0d, expected 0000 urc=0",
               {bclk[1], lrclk[1], sdata[1], sreq[1]}, urc[1]);
    end
    rst_in = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 7) begin
        checks++;
        if (sreq[1] !== 1'b0) begin
          errors++; $display("FAIL midframe_req_early: got %b at clk 7, expected 0", sreq[1]);
        end
      end
    end
    checks++;
    if (sreq[1] !== 1'b1) begin
      errors++; $display("FAIL midframe_req: got %b at clk 8, expected 1", sreq[1]);
    end
    capture_frame(1, bits, st, lr_bad, ok);
    checks++;
    if (!ok || bits !== 32'h0000_0000) begin
      errors++; $display("FAIL midframe_frame: got %h ok=%0d, expected 00000000", bits, ok);
    end
  endtask

  task automatic test_param_sweep();
    logic [31:0] bits;
    int unsigned s1, s2, r0, r1;
    int          lr_bad, n, k;
    bit          ok1, ok2;
    logic        prev;
    for (int j = 0; j < 2; j++) begin
      k = (j == 0) ? 0 : 2;
      apply_reset(16'hC0DE, 16'h1E55, 1'b1);
      capture_frame(k, bits, s1, lr_bad, ok1);
      checks++;
      if (!ok1 || bits !== 32'hC0DE_1E55 || lr_bad != 0) begin
        errors++;
        $display("FAIL sweep_bits_div%0d: got %h lr_bad=%0d ok=%0d, expected c0de1e55 lr_bad=0",
                 div_of(k), bits, lr_bad, ok1);
      end
      capture_frame(k, bits, s2, lr_bad, ok2);
      checks++;
      if (!ok2 || (s2 - s1) != 64 * div_of(k)) begin
        errors++;
        $display("FAIL sweep_frame_div%0d: got %0d, expected %0d", div_of(k), s2 - s1, 64 * div_of(k));
      end
      r0 = 0;
      r1 = 0;
      n = 0;
      prev = bclk[k];
      for (int i = 0; i < 8 * div_of(k) && n < 2; i++) begin
        tick();
        if (bclk[k] && !prev) begin
          if (n == 0) r0 = cyc; else r1 = cyc;
          n++;
        end
        prev = bclk[k];
      end
      checks++;
      if (n != 2 || (r1 - r0) != 2 * div_of(k)) begin
        errors++;
        $display("FAIL sweep_bclk_div%0d: got %0d, expected %0d", div_of(k), r1 - r0, 2 * div_of(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_collision();
    test_saturation();
    test_reset_mid_frame();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
